// File: rtl/jt49_pkg.sv
// Shared PSG definitions: envelope register addresses and shape bit positions.
package jt49_pkg;

  localparam logic [3:0] JT49_ENV_PER_LO = 4'hB;
  localparam logic [3:0] JT49_ENV_PER_HI = 4'hC;
  localparam logic [3:0] JT49_ENV_SHAPE  = 4'hD;

  // Bit positions inside the 4-bit envelope shape value {CONT,ATT,ALT,HOLD}
  localparam int CONT = 3;
  localparam int ATT  = 2;
  localparam int ALT  = 1;
  localparam int HOLD = 0;

  localparam int JT49_ENV_PRESCALE = 16;

endpackage

// File: rtl/jt49_env_div.sv
// Envelope timebase: cen prescaler feeding a 16-bit period counter that emits a one-cen-wide step.
module jt49_env_div
  import jt49_pkg::*;
#(
  parameter int PRESCALE = JT49_ENV_PRESCALE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [15:0] per,
  input  logic        clr,
  output logic        step
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;
  logic [15:0]   cnt;
  logic [16:0]   cnt_inc;
  logic          tick;

  assign tick    = cen && (pre_cnt == PW'(PRESCALE - 1));
  // Widened increment keeps the >= compare from wrapping at 0xFFFF
  assign cnt_inc = {1'b0, cnt} + 17'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
      step    <= 1'b0;
    end else if (clr) begin
      pre_cnt <= '0;
      cnt     <= '0;
      step    <= 1'b0;
    end else if (cen) begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      step    <= 1'b0;
      if (per == 16'd0) begin
        cnt <= '0;
      end else if (tick) begin
        // Compare against the current per so a lowered period expires at once
        if (cnt_inc >= {1'b0, per}) begin
          cnt  <= '0;
          step <= 1'b1;
        end else begin
          cnt <= cnt_inc[15:0];
        end
      end
    end
  end

endmodule

// File: rtl/jt49_env_ctl.sv
// Envelope control front-end: period/shape registers, restart handshake, read mux, step timebase.
module jt49_env_ctl
  import jt49_pkg::*;
#(
  parameter int PRESCALE = JT49_ENV_PRESCALE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       step,
  output logic       null_period,
  output logic       restart,
  output logic [3:0] ctrl
);

  logic [15:0] per;
  logic        shape_wr;

  assign shape_wr = wr && (addr == JT49_ENV_SHAPE);

  // restart handshake: set by a shape write, consumed by the next cen edge without a new write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per     <= '0;
      ctrl    <= '0;
      restart <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          JT49_ENV_PER_LO: per[7:0]  <= din;
          JT49_ENV_PER_HI: per[15:8] <= din;
          JT49_ENV_SHAPE:  ctrl      <= din[3:0];
          default: ;
        endcase
      end
      if (shape_wr) restart <= 1'b1;
      else if (cen) restart <= 1'b0;
    end
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      JT49_ENV_PER_LO: dout = per[7:0];
      JT49_ENV_PER_HI: dout = per[15:8];
      JT49_ENV_SHAPE:  dout = {4'h0, ctrl};
      default:         dout = 8'h00;
    endcase
  end

  assign null_period = (per == 16'd0);

  jt49_env_div #(
    .PRESCALE(PRESCALE)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .cen  (cen),
    .per  (per),
    .clr  (shape_wr),
    .step (step)
  );

endmodule
